// File: rtl/digital_pll_lock_monitor.sv
// PLL lock monitor: counts PLL clock cycles per reference (osc) period and tracks lock/loss-of-lock.
// Optional build macro PLL_MON_TIMEOUT_EN: a saturated counter closes a window as out of range.
module digital_pll_lock_monitor #(
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned CW         = 8
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          enable,
  input  logic          osc,
  input  logic [4:0]    div,
  input  logic          clear_lost,
  output logic          locked,
  output logic          lock_lost,
  output logic [CW-1:0] meas,
  output logic          meas_valid
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [GW-1:0] GOOD_END = GW'(LOCK_CNT);
  localparam logic [BW-1:0] BAD_END  = BW'(UNLOCK_CNT);
  localparam logic [CW:0]   TOL_X    = (CW+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ALIGN, ACQUIRE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] meas_d, win_val;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [BW-1:0] bad_q, bad_d, bad_inc;
  logic          locked_d, mv_d, lost_set;
  logic          osc_s1, osc_s2, osc_s3, osc_edge;
  logic          win_timeout, win_end, in_range;
  logic [CW:0]   win_x, div_x, diff;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      osc_s1 <= 1'b0;
      osc_s2 <= 1'b0;
      osc_s3 <= 1'b0;
    end else begin
      osc_s1 <= osc;
      osc_s2 <= osc_s1;
      osc_s3 <= osc_s2;
    end
  end

  assign osc_edge = osc_s2 & ~osc_s3;

`ifdef PLL_MON_TIMEOUT_EN
  assign win_timeout = (cnt_q == CNT_MAX) && !osc_edge;
`else
  assign win_timeout = 1'b0;
`endif

  assign win_end  = osc_edge | win_timeout;
  assign win_val  = osc_edge ? cnt_q : CNT_MAX;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
  assign good_inc = good_q + 1'b1;
  assign bad_inc  = bad_q + 1'b1;

  // Judge the value being captured this cycle so locked moves with meas_valid.
  assign win_x    = {1'b0, win_val};
  assign div_x    = (CW+1)'(div);
  assign diff     = (win_x >= div_x) ? (win_x - div_x) : (div_x - win_x);
  assign in_range = (div >= 5'd2) && (diff <= TOL_X);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    meas_d   = meas;
    mv_d     = 1'b0;
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked;
    lost_set = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        good_d   = '0;
        bad_d    = '0;
        locked_d = 1'b0;
        if (enable) state_d = ALIGN;
      end
      ALIGN: begin
        cnt_d = '0;
        if (osc_edge) begin
          cnt_d   = {{(CW-1){1'b0}}, 1'b1};
          good_d  = '0;
          bad_d   = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE, LOCKED: begin
        cnt_d = cnt_inc;
        if (win_end) begin
          cnt_d  = {{(CW-1){1'b0}}, 1'b1};
          meas_d = win_val;
          mv_d   = 1'b1;
          if (state_q == ACQUIRE) begin
            if (!in_range) begin
              good_d = '0;
            end else if (good_inc == GOOD_END) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              good_d   = '0;
              bad_d    = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            if (in_range) begin
              bad_d = '0;
            end else if (bad_inc == BAD_END) begin
              state_d  = ACQUIRE;
              locked_d = 1'b0;
              lost_set = 1'b1;
              good_d   = '0;
              bad_d    = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything and is not a loss-of-lock event.
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      meas_d   = meas;
      mv_d     = 1'b0;
      good_d   = '0;
      bad_d    = '0;
      locked_d = 1'b0;
      lost_set = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      meas       <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      meas       <= meas_d;
      meas_valid <= mv_d;
      locked     <= locked_d;
      if (lost_set)        lock_lost <= 1'b1;
      else if (clear_lost) lock_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digital_pll_lock_monitor.sv
// Directed bench for digital_pll_lock_monitor (TOL=1, LOCK_CNT=4, UNLOCK_CNT=2, CW=8).
module tb_digital_pll_lock_monitor;

  logic       clock = 1'b0;
  logic       resetb, enable, osc, clear_lost;
  logic [4:0] div;
  logic       locked, lock_lost, meas_valid;
  logic [7:0] meas;

  int         n_cmp = 0;
  int         n_err = 0;
  int         mv_seen;
  logic [7:0] last_meas;
  logic       last_locked, last_lost;

  always #5 clock = ~clock;

  digital_pll_lock_monitor #(
    .TOL(1), .LOCK_CNT(4), .UNLOCK_CNT(2), .CW(8)
  ) dut (
    .clock(clock), .resetb(resetb), .enable(enable), .osc(osc), .div(div),
    .clear_lost(clear_lost), .locked(locked), .lock_lost(lock_lost),
    .meas(meas), .meas_valid(meas_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One osc period of p cycles (h high), starting at posedge+1; records any meas_valid.
  task automatic osc_period(input int p, input int h, input int clr_at);
    mv_seen = 0;
    for (int i = 0; i < p; i++) begin
      osc        = (i < h);
      clear_lost = (i == clr_at);
      @(negedge clock);
      if (meas_valid) begin
        mv_seen++;
        last_meas   = meas;
        last_locked = locked;
        last_lost   = lock_lost;
      end
      @(posedge clock); #1;
    end
    clear_lost = 1'b0;
  endtask

  // Starts a period of p cycles; its rising edge closes the previous window.
  task automatic win(input string tag, input int p, input int e_meas, input logic e_lk,
                     input logic e_lost);
    osc_period(p, p / 2, -1);
    chk({tag, ".mv"}, mv_seen, 1);
    chk({tag, ".meas"}, last_meas, e_meas);
    chk({tag, ".locked"}, last_locked, e_lk);
    chk({tag, ".lost"}, last_lost, e_lost);
  endtask

  int acq_p[9] = '{8, 9, 7, 11, 8, 8, 8, 8, 8};
  int acq_m[9] = '{14, 8, 9, 7, 11, 8, 8, 8, 8};

  initial begin
    resetb = 1'b0; enable = 1'b0; osc = 1'b0; clear_lost = 1'b0; div = 5'd8;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.locked", locked, 0);
    chk("rst.lost", lock_lost, 0);
    chk("rst.meas", meas, 0);
    chk("rst.mv", meas_valid, 0);
    @(posedge clock); #1;
    resetb = 1'b1;

    // Acquire at div=8, period 8
    enable = 1'b1;
    osc_period(8, 4, -1);
    chk("align.mv", mv_seen, 0);
    win("acq8a", 8, 8, 0, 0);
    win("acq8b", 8, 8, 0, 0);
    win("acq8c", 8, 8, 0, 0);
    win("acq8d", 8, 8, 1, 0);

    // Period 12 while locked: unlock on 2nd out-of-range window
    win("p12a", 12, 8, 1, 0);
    win("p12b", 12, 12, 1, 0);
    win("p12c", 12, 12, 0, 1);
    clear_lost = 1'b1;
    @(posedge clock); #1;
    clear_lost = 1'b0;
    @(posedge clock); #1;
    chk("clear.lost", lock_lost, 0);

    // Jittered acquisition; the 11 resets the good count
    for (int j = 0; j < 9; j++)
      win($sformatf("jit%0d", j), acq_p[j], acq_m[j], (j == 8), 0);

    // +/-TOL windows never unlock
    win("tol9", 9, 8, 1, 0);
    win("tol7", 7, 9, 1, 0);
    win("tol9b", 9, 7, 1, 0);
    win("tol8", 8, 9, 1, 0);

    // clear_lost coinciding with the unlock window: set wins
    win("sim12a", 12, 8, 1, 0);
    win("sim12b", 12, 12, 1, 0);
    osc_period(12, 6, 2);
    chk("sim.mv", mv_seen, 1);
    chk("sim.meas", last_meas, 12);
    chk("sim.locked", last_locked, 0);
    chk("sim.lost", last_lost, 1);
    chk("sim.lost_hold", lock_lost, 1);

    // Relock, then drop enable
    win("rl0", 8, 12, 0, 1);
    win("rl1", 8, 8, 0, 1);
    win("rl2", 8, 8, 0, 1);
    win("rl3", 8, 8, 0, 1);
    win("rl4", 8, 8, 1, 1);
    enable = 1'b0;
    @(posedge clock); #1;
    chk("dis.locked", locked, 0);
    chk("dis.lost", lock_lost, 1);
    chk("dis.mv", meas_valid, 0);
    repeat (3) begin @(posedge clock); #1; end

    // Re-enable and relock, then stop osc
    enable = 1'b1;
    osc_period(8, 4, -1);
    chk("realign.mv", mv_seen, 0);
    win("re1", 8, 8, 0, 1);
    win("re2", 8, 8, 0, 1);
    win("re3", 8, 8, 0, 1);
    win("re4", 8, 8, 1, 1);
    osc_period(600, 0, -1);
`ifdef PLL_MON_TIMEOUT_EN
    chk("stop.mv", mv_seen, 2);
    chk("stop.meas", last_meas, 255);
    chk("stop.locked", locked, 0);
    chk("stop.lost", lock_lost, 1);
    osc_period(8, 4, -1);
`else
    chk("stop.mv", mv_seen, 0);
    chk("stop.locked", locked, 1);
    win("resume", 8, 255, 1, 1);
`endif

    // Asynchronous reset in mid-window
    #3;
    resetb = 1'b0;
    #1;
    chk("arst.locked", locked, 0);
    chk("arst.lost", lock_lost, 0);
    chk("arst.meas", meas, 0);
    chk("arst.mv", meas_valid, 0);
    @(posedge clock); #1;
    resetb = 1'b1;

    // div=1 and div=0 never lock
    div = 5'd1;
    osc_period(4, 2, -1);
    chk("d1align.mv", mv_seen, 0);
    for (int j = 0; j < 6; j++) win($sformatf("div1_%0d", j), 4, 4, 0, 0);
    div = 5'd0;
    for (int j = 0; j < 5; j++) win($sformatf("div0_%0d", j), 4, 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
